tdm_demux_one_four: RTL

Time-division demultiplexer: receives one interleaved sample stream carrying four channels (slot 0..3, one sample per valid beat) and distributes each frame to four parallel registered outputs. It is the receive end of the 4:1 channel-select path already in the lab designs: the mux side picks w0..w3 by select. This block recovers the slot position from a frame marker, rebuilds w0..w3 and presents whole frames atomically. It sits between the serial link and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_slot_ctr.sv | 40 ++++
 rtl/tdm_demux_one_four.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the four-slot TDM receive path.
//   SLOTS  : channels carried per frame
//   SLOT_W : width of the slot position counter
//   state_e: framing state (HUNT = searching for a marker, LOCKED = aligned)
package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the TDM demultiplexer.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears slot to 0
//   en       : advance by one slot (wraps 3 -> 0)
//   load_one : accepted frame marker, slot becomes 1 (marker beat was slot 0)
//   clr      : force slot back to 0
//   slot     : current slot position
// Priority: clr over load_one over en.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_one,
    input  logic              clr,
    output logic [SLOT_W-1:0] slot
);

    logic [SLOT_W-1:0] slot_r;

    // Slot register: clear, load-after-marker, or wrap-around increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= {SLOT_W{1'b0}};
        end else if (clr) begin
            slot_r <= {SLOT_W{1'b0}};
        end else if (load_one) begin
            slot_r <= SLOT_W'(1'b1);
        end else if (en) begin
            slot_r <= slot_r + SLOT_W'(1'b1);
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;

endmodule

// File: rtl/tdm_demux_one_four.sv
// Four-channel time-division demultiplexer.
// Recovers slot alignment from a slot-0 frame marker, collects slots 0..2 in
// shadow registers and publishes a whole frame to y0..y3 on the slot-3 beat,
// so consumers never observe a partially received frame.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   din         : serial sample for the current slot
//   din_valid   : beat qualifier for din and frame_sync
//   frame_sync  : marks the slot-0 sample
//   y0..y3      : last complete frame, channel 0..3
//   frame_valid : one-cycle pulse after y0..y3 were updated
//   locked      : high while aligned to the frame marker
//   sync_err    : one-cycle pulse after a missing or misplaced marker
module tdm_demux_one_four
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    state_e            state_r;
    logic [SLOT_W-1:0] slot_s;
    logic              ctr_en_s;
    logic              ctr_load_s;
    logic              ctr_clr_s;
    logic [WIDTH-1:0]  shadow0_r;
    logic [WIDTH-1:0]  shadow1_r;
    logic [WIDTH-1:0]  shadow2_r;
    logic [WIDTH-1:0]  y0_r;
    logic [WIDTH-1:0]  y1_r;
    logic [WIDTH-1:0]  y2_r;
    logic [WIDTH-1:0]  y3_r;
    logic              frame_valid_r;
    logic              sync_err_r;

    // Counter controls: any marker beat realigns to slot 1; a missing marker in
    // LOCKED drops back to slot 0; ordinary LOCKED beats advance. In HUNT,
    // unmarked beats leave the counter parked at 0.
    always_comb begin
        ctr_en_s   = 1'b0;
        ctr_load_s = 1'b0;
        ctr_clr_s  = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                ctr_load_s = 1'b1;
            end else if (state_r == LOCKED) begin
                if (slot_s == 2'd0) begin
                    ctr_clr_s = 1'b1;
                end else begin
                    ctr_en_s = 1'b1;
                end
            end else begin
                ctr_en_s = 1'b0;
            end
        end else begin
            ctr_en_s = 1'b0;
        end
    end

    tdm_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (ctr_en_s),
        .load_one (ctr_load_s),
        .clr      (ctr_clr_s),
        .slot     (slot_s)
    );

    // Framing FSM, shadow capture and frame publication. Pulses default low
    // every cycle so each lasts exactly one cycle after its beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= HUNT;
            shadow0_r     <= {WIDTH{1'b0}};
            shadow1_r     <= {WIDTH{1'b0}};
            shadow2_r     <= {WIDTH{1'b0}};
            y0_r          <= {WIDTH{1'b0}};
            y1_r          <= {WIDTH{1'b0}};
            y2_r          <= {WIDTH{1'b0}};
            y3_r          <= {WIDTH{1'b0}};
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            if (din_valid) begin
                case (state_r)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow0_r <= din;
                            state_r   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (slot_s == 2'd0) begin
                            if (frame_sync) begin
                                shadow0_r <= din;
                            end else begin
                                sync_err_r <= 1'b1;
                                state_r    <= HUNT;
                            end
                        end else if (frame_sync) begin
                            // Misplaced marker: abandon the partial frame and
                            // treat this beat as the start of a new one.
                            sync_err_r <= 1'b1;
                            shadow0_r  <= din;
                        end else begin
                            case (slot_s)
                                2'd1:    shadow1_r <= din;
                                2'd2:    shadow2_r <= din;
                                2'd3: begin
                                    y0_r          <= shadow0_r;
                                    y1_r          <= shadow1_r;
                                    y2_r          <= shadow2_r;
                                    y3_r          <= din;
                                    frame_valid_r <= 1'b1;
                                end
                                default: shadow0_r <= shadow0_r;
                            endcase
                        end
                    end
                    default: state_r <= HUNT;
                endcase
            end
        end
    end

    assign y0          = y0_r;
    assign y1          = y1_r;
    assign y2          = y2_r;
    assign y3          = y3_r;
    assign frame_valid = frame_valid_r;
    assign sync_err    = sync_err_r;
    assign locked      = (state_r == LOCKED);

endmodule
